audio_mixer_tdm: RTL

Parametrised successor to the fixed six-PSG panner/mixer. Mixes NCH unsigned audio channels into a stereo pair using per-channel 4-bit volume and independent left/right enables, programmable from the Z80 I/O bus. The sum is time-multiplexed, one channel per clock, then saturated. The result drives a first-order delta-sigma DAC per side and a parallel sample output for digital audio sinks. It sits between the sound sources (PSGs, beeper, Specdrum, SAA, MIDI) and the board audio pins.

---
 rtl/audio_mixer_tdm.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/audio_mixer_tdm.sv
// audio_mixer_tdm: time-multiplexed stereo mixer for NCH unsigned channels.
// Each channel has a 4-bit volume and independent left/right enables, set
// through the Z80 I/O bus. A channel counter visits one channel per clock.
// Each result is scaled, panned and summed, then shifted and saturated into
// OW-bit samples. Each sample drives a first-order delta-sigma DAC.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   a, iorq_n, rd_n, wr_n  Z80 address low byte and active-low strobes
//   din / dout, oe         CPU write data / read data and its bus-mux enable
//   ch_data                channel k in bits [k*IW +: IW]
//   sample_l, sample_r     latest mixed sample per side
//   sample_valid           one-clock pulse when sample_l/r update
//   dac_l, dac_r           delta-sigma bitstreams
module audio_mixer_tdm #(
  parameter int          NCH       = 8,
  parameter int          IW        = 8,
  parameter int          OW        = 10,
  parameter int          SHIFT     = 1,
  parameter logic [7:0]  ADDR_SEL  = 8'hF6,
  parameter logic [7:0]  ADDR_DATA = 8'hF7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        a,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              oe,
  input  logic [NCH*IW-1:0] ch_data,
  output logic [OW-1:0]     sample_l,
  output logic [OW-1:0]     sample_r,
  output logic              sample_valid,
  output logic              dac_l,
  output logic              dac_r
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = IW + $clog2(NCH) + 1;
  localparam int SW = (AW > OW) ? AW : OW;
  localparam int DW = OW + 2;

  localparam logic [CW-1:0] LAST = CW'(NCH - 1);
  localparam logic [4:0]    NCH5 = 5'(NCH);
  localparam logic [SW-1:0] MAXV = SW'((1 << OW) - 1);
  localparam logic [DW-1:0] INT0 = DW'(1) << OW;

  logic [3:0]    r_idx;
  logic [7:0]    r_cfg [NCH];
  logic [CW-1:0] r_cnt;
  logic          r_primed;
  logic [IW-1:0] r_p_l, r_p_r;
  logic [AW-1:0] r_acc_l, r_acc_r;
  logic [OW-1:0] r_sample_l, r_sample_r;
  logic          r_valid;
  logic [DW-1:0] r_int_l, r_int_r;
  logic          r_dac_l, r_dac_r;

  logic          w_idx_ok;
  logic [CW-1:0] w_idx_c;
  logic          w_wr_sel, w_wr_data;
  logic [IW-1:0] w_ch;
  logic [IW+4:0] w_prod;
  logic [IW-1:0] w_term;
  logic [AW-1:0] w_sum_l, w_sum_r;
  logic [SW-1:0] w_ext_l, w_ext_r;
  logic [OW-1:0] w_sat_l, w_sat_r;
  logic [DW-1:0] w_delta_l, w_delta_r;

  assign w_idx_ok  = {1'b0, r_idx} < NCH5;
  assign w_idx_c   = r_idx[CW-1:0];
  assign w_wr_sel  = (a == ADDR_SEL)  && !iorq_n && !wr_n;
  assign w_wr_data = (a == ADDR_DATA) && !iorq_n && !wr_n;
  assign oe        = (a == ADDR_DATA) && !iorq_n && !rd_n;

  always_comb begin
    dout = '0;
    if (w_idx_ok) dout = r_cfg[w_idx_c];
  end

  // Stage 1 term: (ch * (vol+1)) >> 4 always fits back into IW bits.
  assign w_ch   = ch_data[r_cnt*IW +: IW];
  assign w_prod = (IW+5)'(w_ch) * (IW+5)'({1'b0, r_cfg[r_cnt][3:0]} + 5'd1);
  assign w_term = IW'(w_prod >> 4);

  // The last channel's term is still in r_p when cnt wraps, so it is folded
  // in here rather than into the accumulator.
  assign w_sum_l = r_acc_l + AW'(r_p_l);
  assign w_sum_r = r_acc_r + AW'(r_p_r);
  assign w_ext_l = SW'(w_sum_l >> SHIFT);
  assign w_ext_r = SW'(w_sum_r >> SHIFT);
  assign w_sat_l = (w_ext_l > MAXV) ? '1 : OW'(w_ext_l);
  assign w_sat_r = (w_ext_r > MAXV) ? '1 : OW'(w_ext_r);

  // Adding {msb,msb,0..0} is a subtract of 2^OW whenever the integrator's
  // top bit is set, which is the feedback of the 1-bit quantiser.
  assign w_delta_l = DW'(r_sample_l) + {r_int_l[DW-1], r_int_l[DW-1], {OW{1'b0}}};
  assign w_delta_r = DW'(r_sample_r) + {r_int_r[DW-1], r_int_r[DW-1], {OW{1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      for (int unsigned k = 0; k < NCH; k++) r_cfg[k] <= 8'hCF;
      r_cnt      <= '0;
      r_primed   <= 1'b0;
      r_p_l      <= '0;
      r_p_r      <= '0;
      r_acc_l    <= '0;
      r_acc_r    <= '0;
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_valid    <= 1'b0;
      r_int_l    <= INT0;
      r_int_r    <= INT0;
      r_dac_l    <= 1'b0;
      r_dac_r    <= 1'b0;
    end else begin
      if (w_wr_sel) r_idx <= din[3:0];
      if (w_wr_data && w_idx_ok) r_cfg[w_idx_c] <= din;

      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      r_p_l <= r_cfg[r_cnt][7] ? w_term : '0;
      r_p_r <= r_cfg[r_cnt][6] ? w_term : '0;

      r_valid <= 1'b0;
      if (r_cnt == '0) begin
        r_acc_l  <= '0;
        r_acc_r  <= '0;
        r_primed <= 1'b1;
        if (r_primed) begin
          r_sample_l <= w_sat_l;
          r_sample_r <= w_sat_r;
          r_valid    <= 1'b1;
        end
      end else begin
        r_acc_l <= w_sum_l;
        r_acc_r <= w_sum_r;
      end

      r_int_l <= r_int_l + w_delta_l;
      r_int_r <= r_int_r + w_delta_r;
      r_dac_l <= r_int_l[DW-1];
      r_dac_r <= r_int_r[DW-1];
    end
  end

  assign sample_l     = r_sample_l;
  assign sample_r     = r_sample_r;
  assign sample_valid = r_valid;
  assign dac_l        = r_dac_l;
  assign dac_r        = r_dac_r;

endmodule
